// File: rtl/sseg_scan_ctrl.sv
// Timed digit-scan scheduler for a multiplexed 7-segment display.
// Optional SSEG_DIM_EN adds a DUTY input for per-digit PWM dimming.
module sseg_scan_ctrl #(
  parameter int DIGITS    = 2,
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 16,
  parameter int CNT_W     = 16
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       EN,
  input  logic [7*DIGITS-1:0]        SEG_IN,
  input  logic                       LOAD,
`ifdef SSEG_DIM_EN
  input  logic [3:0]                 DUTY,
`endif
  output logic                       PEND,
  output logic [6:0]                 SSEG_Data,
  output logic [DIGITS-1:0]          Anode,
  output logic [$clog2(DIGITS)-1:0]  DIG_IDX,
  output logic                       FRAME
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int SEG_W = 7 * DIGITS;
  localparam logic [CNT_W-1:0] BLANK_LAST =
    CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] ON_LAST =
    CNT_W'(SCAN_DIV - BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              frame_start;
  logic [SEG_W-1:0]  act_q, pnd_q;
  logic [6:0]        act_dig [DIGITS];
  logic [6:0]        seg_d;
  logic [DIGITS-1:0] anode_d;

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    assign act_dig[k] = act_q[7*k +: 7];
  end

  assign DIG_IDX = idx_q;

  // State, slot counter and digit index registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: blank dead-time, then on-time, digit by digit
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    frame_start = 1'b0;
    if (!EN) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d     = BLANK;
          cnt_d       = '0;
          idx_d       = '0;
          frame_start = 1'b1;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ON: begin
          if (cnt_q == ON_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d       = '0;
              frame_start = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

`ifdef SSEG_DIM_EN
  logic [3:0] dcnt_q, dcnt_d;

  // PWM phase restarts on every entry to ON
  always_comb begin
    dcnt_d = dcnt_q + 4'd1;
    if (state_d == ON && state_q != ON) begin
      dcnt_d = 4'd0;
    end
  end

  // PWM phase register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dcnt_q <= 4'd0;
    end else begin
      dcnt_q <= dcnt_d;
    end
  end
`endif

  // Output decode from the state being entered
  always_comb begin
    seg_d   = '0;
    anode_d = '0;
    if (state_d == ON) begin
      seg_d = act_dig[idx_d];
`ifdef SSEG_DIM_EN
      if (DUTY == 4'hF || dcnt_d < DUTY) begin
        anode_d = DIGITS'(1) << idx_d;
      end
`else
      anode_d = DIGITS'(1) << idx_d;
`endif
    end
  end

  // Registered drive lines and frame pulse
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      SSEG_Data <= '0;
      Anode     <= '0;
      FRAME     <= 1'b0;
    end else begin
      SSEG_Data <= seg_d;
      Anode     <= anode_d;
      FRAME     <= frame_start;
    end
  end

  // Double buffer: new data reaches the display only at a frame start
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      act_q <= '0;
      pnd_q <= '0;
      PEND  <= 1'b0;
    end else begin
      if (LOAD) begin
        pnd_q <= SEG_IN;
      end
      if (frame_start) begin
        if (LOAD) begin
          act_q <= SEG_IN;
        end else if (PEND) begin
          act_q <= pnd_q;
        end
        PEND <= 1'b0;
      end else if (LOAD) begin
        PEND <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl: frame-position model plus directed literals.
// Builds with or without SSEG_DIM_EN.
module tb_sseg_scan_ctrl;

  localparam int DG = 2;
`ifdef SSEG_DIM_EN
  localparam int S = 40;
  localparam int B = 8;
`else
  localparam int S = 8;
  localparam int B = 2;
`endif
  localparam int F  = DG * S;
  localparam int SW = 7 * DG;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          EN = 1'b0;
  logic          LOAD = 1'b0;
  logic [SW-1:0] SEG_IN = '0;
  logic [3:0]    duty = 4'd4;
  logic          PEND;
  logic [6:0]    SSEG_Data;
  logic [DG-1:0] Anode;
  logic          DIG_IDX;
  logic          FRAME;

  sseg_scan_ctrl #(
    .DIGITS(DG), .SCAN_DIV(S), .BLANK_CYC(B), .CNT_W(16)
  ) dut (
    .CLK(CLK), .nRST(nRST), .EN(EN),
    .SEG_IN(SEG_IN), .LOAD(LOAD),
`ifdef SSEG_DIM_EN
    .DUTY(duty),
`endif
    .PEND(PEND), .SSEG_Data(SSEG_Data), .Anode(Anode),
    .DIG_IDX(DIG_IDX), .FRAME(FRAME)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int ph = 0;
  bit chk_on = 1'b0;

  // Model: position inside the frame decides everything
  bit            m_run = 1'b0;
  int            m_t = 0;
  logic [SW-1:0] m_act = '0;
  logic [SW-1:0] m_pnd = '0;
  logic          m_pend = 1'b0;
  logic [DG-1:0] m_an = '0;
  logic [6:0]    m_seg = '0;
  logic          m_idx = 1'b0;
  logic          m_frm = 1'b0;

  always @(posedge CLK or negedge nRST) begin
    bit fs;
    int d, s, k;
    bit lit;
    if (!nRST) begin
      m_run = 0; m_t = 0; m_act = '0; m_pnd = '0;
      m_pend = 0; m_an = '0; m_seg = '0;
      m_idx = 0; m_frm = 0;
    end else begin
      fs = 0;
      if (!EN) begin
        m_run = 0;
        m_t = 0;
      end else begin
        if (m_run) m_t = (m_t + 1) % F;
        else begin
          m_run = 1;
          m_t = 0;
        end
        fs = (m_t == 0);
      end
      if (fs) begin
        if (LOAD) m_act = SEG_IN;
        else if (m_pend) m_act = m_pnd;
        m_pend = 0;
      end else if (LOAD) begin
        m_pend = 1;
      end
      if (LOAD) m_pnd = SEG_IN;
      m_an = '0; m_seg = '0; m_idx = 0; m_frm = 0;
      if (m_run) begin
        d = m_t / S;
        s = m_t % S;
        m_idx = d[0];
        m_frm = (m_t == 0);
        if (s >= B) begin
          m_seg = m_act[7*d +: 7];
          k = s - B;
          lit = 1;
`ifdef SSEG_DIM_EN
          lit = (duty == 4'hF) || ((k % 16) < int'(duty));
`endif
          if (lit) m_an = DG'(1) << d;
        end
      end
    end
  end

  // Cycle compare against the model
  always @(posedge CLK) begin
    #1;
    if (chk_on) begin
      n_cmp++;
      if (Anode !== m_an || SSEG_Data !== m_seg ||
          DIG_IDX !== m_idx || FRAME !== m_frm ||
          PEND !== m_pend) begin
        n_bad++;
        $display("FAIL cycle t=%0t got an=%b seg=%h idx=%0d frm=%b pend=%b want an=%b seg=%h idx=%0d frm=%b pend=%b",
          $time, Anode, SSEG_Data, DIG_IDX, FRAME, PEND,
          m_an, m_seg, m_idx, m_frm, m_pend);
      end
    end
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge CLK);
    ph += n;
  endtask

  task automatic go(int t);
    if (t > ph) tick(t - ph);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk_on = 1'b1;
    chk("rst_anode", 32'(Anode), 0);
    chk("rst_seg", 32'(SSEG_Data), 0);
    chk("rst_pend", 32'(PEND), 0);
    chk("rst_frame", 32'(FRAME), 0);
    chk("rst_idx", 32'(DIG_IDX), 0);
    nRST = 1'b1;
    tick(1);

    SEG_IN = {7'h06, 7'h3F};
    LOAD = 1'b1;
    tick(1);
    LOAD = 1'b0;
    chk("pre_en_pend", 32'(PEND), 1);
    chk("pre_en_anode", 32'(Anode), 0);

    EN = 1'b1;
    tick(1);
    ph = 0;
    chk("f0_frame", 32'(FRAME), 1);
    chk("f0_pend", 32'(PEND), 0);
    chk("f0_anode", 32'(Anode), 0);
    go(1);
    chk("f0_frame_low", 32'(FRAME), 0);
    go(B);
    chk("d0_anode", 32'(Anode), 1);
    chk("d0_seg", 32'(SSEG_Data), 32'h3F);
    go(S - 1);
    chk("d0_last_seg", 32'(SSEG_Data), 32'h3F);
    go(S);
    chk("d1_blank_an", 32'(Anode), 0);
    chk("d1_blank_idx", 32'(DIG_IDX), 1);
    go(S + B);
    chk("d1_anode", 32'(Anode), 2);
    chk("d1_seg", 32'(SSEG_Data), 32'h06);
    go(F);
    chk("f1_frame", 32'(FRAME), 1);

    go(F + B + 2);
    SEG_IN = {7'h5B, 7'h4F};
    LOAD = 1'b1;
    tick(1);
    LOAD = 1'b0;
    chk("mid_pend", 32'(PEND), 1);
    chk("mid_old_seg", 32'(SSEG_Data), 32'h3F);
    go(2 * F);
    chk("f2_frame", 32'(FRAME), 1);
    chk("f2_pend", 32'(PEND), 0);
    go(2 * F + B);
    chk("f2_d0_seg", 32'(SSEG_Data), 32'h4F);
    go(2 * F + S + B);
    chk("f2_d1_seg", 32'(SSEG_Data), 32'h5B);

    SEG_IN = {7'h01, 7'h01};
    LOAD = 1'b1;
    tick(1);
    SEG_IN = {7'h7F, 7'h7F};
    tick(1);
    LOAD = 1'b0;
    go(3 * F + B);
    chk("last_win_d0", 32'(SSEG_Data), 32'h7F);
    go(3 * F + S + B);
    chk("last_win_d1", 32'(SSEG_Data), 32'h7F);

    go(4 * F - 1);
    SEG_IN = {7'h12, 7'h24};
    LOAD = 1'b1;
    tick(1);
    LOAD = 1'b0;
    chk("coin_frame", 32'(FRAME), 1);
    chk("coin_pend", 32'(PEND), 0);
    go(4 * F + B);
    chk("coin_seg", 32'(SSEG_Data), 32'h24);

    go(4 * F + S + B + 1);
    chk("d1_on_an", 32'(Anode), 2);
    EN = 1'b0;
    tick(1);
    chk("dis_anode", 32'(Anode), 0);
    chk("dis_seg", 32'(SSEG_Data), 0);
    chk("dis_idx", 32'(DIG_IDX), 0);
    SEG_IN = {7'h33, 7'h55};
    LOAD = 1'b1;
    tick(1);
    LOAD = 1'b0;
    chk("dis_pend", 32'(PEND), 1);
    tick(3);
    chk("dis_pend_kept", 32'(PEND), 1);
    EN = 1'b1;
    tick(1);
    ph = 0;
    chk("re_frame", 32'(FRAME), 1);
    chk("re_idx", 32'(DIG_IDX), 0);
    chk("re_pend", 32'(PEND), 0);
    go(B);
    chk("re_seg", 32'(SSEG_Data), 32'h55);

    SEG_IN = {7'h11, 7'h22};
    LOAD = 1'b1;
    tick(1);
    LOAD = 1'b0;
    #2;
    nRST = 1'b0;
    #1;
    chk("arst_anode", 32'(Anode), 0);
    chk("arst_seg", 32'(SSEG_Data), 0);
    chk("arst_pend", 32'(PEND), 0);
    @(negedge CLK);
    nRST = 1'b1;
    tick(1);
    ph = 0;
    chk("arst_frame", 32'(FRAME), 1);
    chk("arst_idx", 32'(DIG_IDX), 0);
    go(B);
    chk("arst_seg0", 32'(SSEG_Data), 0);

`ifdef SSEG_DIM_EN
    duty = 4'd4;
    go(F);
    go(F + B + 3);
    chk("dim4_c3", 32'(Anode), 1);
    go(F + B + 4);
    chk("dim4_c4", 32'(Anode), 0);
    go(F + B + 16);
    chk("dim4_c16", 32'(Anode), 1);
    go(F + B + 20);
    chk("dim4_c20", 32'(Anode), 0);
    go(F + S);
    duty = 4'hF;
    go(F + S + B + 20);
    chk("dim15_c20", 32'(Anode), 2);
    go(F + S + B + 31);
    chk("dim15_c31", 32'(Anode), 2);
    go(2 * F);
    duty = 4'd0;
    go(2 * F + B);
    chk("dim0_c0", 32'(Anode), 0);
    go(2 * F + B + 17);
    chk("dim0_c17", 32'(Anode), 0);
    duty = 4'd4;
`endif

    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      EN = ($urandom_range(0, 49) != 0);
      LOAD = ($urandom_range(0, 7) == 0);
      SEG_IN = SW'($urandom);
`ifdef SSEG_DIM_EN
      if ((i % 64) == 0) duty = 4'($urandom);
`endif
      if (i == 300) begin
        #2;
        nRST = 1'b0;
        #1;
        chk("rnd_arst_an", 32'(Anode), 0);
        @(negedge CLK);
        nRST = 1'b1;
      end
    end
    LOAD = 1'b0;
    repeat (4) @(negedge CLK);
    chk_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule
